mem_port_arbiter: RTL and testbench

- Shares one memory-bank port (DataMem or VGATextCard word port, 11-bit word address) between two requesters.
- Requester 0 is the CPU data path; requester 1 is a DMA/debug loader.
- Arbitrates round-robin with an optional bounded lock for bursts.
- Sequences every access as a two-state issue/response transaction and produces a CPU stall that holds the PC while a CPU access is pending.

---
 rtl/mem_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single synchronous-read memory bank port.
// Round-robin with a bounded lock; each access is one ACCESS cycle then one RESP cycle.
module mem_port_arbiter #(
  parameter int AW       = 11,
  parameter int DW       = 32,
  parameter int MAX_LOCK = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          lock0,
  input  logic [AW-1:0] addr0,
  input  logic [3:0]    be0,
  input  logic [DW-1:0] wdata0,
  input  logic          req1,
  input  logic          lock1,
  input  logic [AW-1:0] addr1,
  input  logic [3:0]    be1,
  input  logic [DW-1:0] wdata1,
  output logic          mem_en,
  output logic [3:0]    mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic [1:0]    grant,
  output logic          cpu_stall,
  output logic          busy,
  output logic [1:0]    dbg_state
);

  // Handshake: a requester raises req with stable inputs and holds them until its
  // one-cycle ack; rdataN is valid from that ack until the next ack to the same side.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCESS = 2'd1, S_RESP = 2'd2} state_t;

  localparam logic [3:0] MAX_LOCK_C = 4'(MAX_LOCK);

  state_t        state_q, state_d;
  logic [1:0]    grant_q, grant_d;
  logic [1:0]    ack_q, ack_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic          rr_q, rr_d;
  logic [3:0]    lock_cnt_q, lock_cnt_d;

  logic          cand0, cand1;
  logic          win;
  logic [3:0]    arb_cnt;
  logic          acked;

  // In RESP the requester just served only competes again if it asked to lock.
  always_comb begin
    cand0   = 1'b0;
    cand1   = 1'b0;
    win     = 1'b0;
    arb_cnt = 4'd0;
    acked   = grant_q[1];
    if (state_q == S_IDLE) begin
      cand0 = req0;
      cand1 = req1;
    end else if (state_q == S_RESP) begin
      cand0 = req0 & (~grant_q[0] | lock0);
      cand1 = req1 & (~grant_q[1] | lock1);
    end
    if (cand0 && cand1) begin
      if (state_q == S_RESP) begin
        if (lock_cnt_q < MAX_LOCK_C) begin
          win     = acked;
          arb_cnt = 4'(lock_cnt_q + 4'd1);
        end else begin
          win     = ~acked;
          arb_cnt = 4'd0;
        end
      end else begin
        win = rr_q;
      end
    end else begin
      win = cand1;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ack_d      = 2'b00;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    rr_d       = rr_q;
    lock_cnt_d = lock_cnt_q;
    case (state_q)
      S_IDLE, S_RESP: begin
        if (cand0 || cand1) begin
          state_d    = S_ACCESS;
          grant_d    = win ? 2'b10 : 2'b01;
          rr_d       = ~win;
          lock_cnt_d = arb_cnt;
        end else begin
          state_d    = S_IDLE;
          grant_d    = 2'b00;
          lock_cnt_d = 4'd0;
        end
      end
      S_ACCESS: begin
        state_d = S_RESP;
        ack_d   = grant_q;
        if (grant_q[0]) rdata0_d = mem_rdata;
        if (grant_q[1]) rdata1_d = mem_rdata;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      grant_q    <= 2'b00;
      ack_q      <= 2'b00;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      rr_q       <= 1'b0;
      lock_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ack_q      <= ack_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
      rr_q       <= rr_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  assign mem_en    = (state_q == S_ACCESS);
  assign mem_addr  = grant_q[1] ? addr1 : addr0;
  assign mem_wdata = grant_q[1] ? wdata1 : wdata0;
  assign mem_we    = mem_en ? (grant_q[1] ? be1 : be0) : 4'b0000;
  assign ack0      = ack_q[0];
  assign ack1      = ack_q[1];
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign grant     = grant_q;
  assign cpu_stall = req0 & ~ack_q[0];
  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: read, byte write, round-robin tie,
// lock limit, reset mid-access and an unlocked held request.
module tb_mem_port_arbiter;

  localparam int AW = 11;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req0 = 1'b0, lock0 = 1'b0, req1 = 1'b0, lock1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [3:0]    be0 = '0, be1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0, mem_rdata = '0;
  logic          mem_en, ack0, ack1, cpu_stall, busy;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, rdata0, rdata1;
  logic [1:0]    grant, dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  // clock / reset
  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(4)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .lock0(lock0), .addr0(addr0), .be0(be0), .wdata0(wdata0),
    .req1(req1), .lock1(lock1), .addr1(addr1), .be1(be1), .wdata1(wdata1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .grant(grant), .cpu_stall(cpu_stall), .busy(busy), .dbg_state(dbg_state)
  );

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // driver tasks: inputs change 1 time unit after posedge, outputs sampled at negedge
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    next_cycle();
    reset = 1'b0;
    req0 = 1'b0; lock0 = 1'b0; req1 = 1'b0; lock1 = 1'b0;
    be0 = '0; be1 = '0;
    next_cycle();
    smp();
  endtask

  initial begin
    // reset state
    do_reset();
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_ack0", 32'(ack0), 32'h0);
    check("rst_ack1", 32'(ack1), 32'h0);
    check("rst_rdata0", rdata0, 32'h0);
    check("rst_rdata1", rdata1, 32'h0);
    check("rst_mem_en", 32'(mem_en), 32'h0);
    check("rst_mem_we", 32'(mem_we), 32'h0);
    check("rst_state", 32'(dbg_state), 32'h0);

    // single CPU read
    next_cycle(); reset = 1'b1; req0 = 1'b1; addr0 = 11'h005; mem_rdata = 32'hDEADBEEF;
    smp();
    check("rd_c0_stall", 32'(cpu_stall), 32'h1);
    check("rd_c0_en", 32'(mem_en), 32'h0);
    next_cycle(); smp();
    check("rd_c1_en", 32'(mem_en), 32'h1);
    check("rd_c1_addr", 32'(mem_addr), 32'h005);
    check("rd_c1_we", 32'(mem_we), 32'h0);
    check("rd_c1_grant", 32'(grant), 32'h1);
    check("rd_c1_stall", 32'(cpu_stall), 32'h1);
    next_cycle(); smp();
    check("rd_c2_ack0", 32'(ack0), 32'h1);
    check("rd_c2_rdata0", rdata0, 32'hDEADBEEF);
    check("rd_c2_stall", 32'(cpu_stall), 32'h0);
    check("rd_c2_en", 32'(mem_en), 32'h0);
    next_cycle(); req0 = 1'b0; smp();
    check("rd_c3_ack0", 32'(ack0), 32'h0);
    check("rd_c3_grant", 32'(grant), 32'h0);
    check("rd_c3_busy", 32'(busy), 32'h0);
    check("rd_c3_rdata0", rdata0, 32'hDEADBEEF);

    // byte write from requester 1
    next_cycle(); req1 = 1'b1; addr1 = 11'h010; be1 = 4'b0100; wdata1 = 32'h00AB0000;
    mem_rdata = 32'h12345678;
    smp();
    check("wr_c0_we", 32'(mem_we), 32'h0);
    next_cycle(); smp();
    check("wr_c1_en", 32'(mem_en), 32'h1);
    check("wr_c1_we", 32'(mem_we), 32'h4);
    check("wr_c1_wdata", mem_wdata, 32'h00AB0000);
    check("wr_c1_addr", 32'(mem_addr), 32'h010);
    check("wr_c1_grant", 32'(grant), 32'h2);
    next_cycle(); smp();
    check("wr_c2_ack1", 32'(ack1), 32'h1);
    check("wr_c2_ack0", 32'(ack0), 32'h0);
    check("wr_c2_we", 32'(mem_we), 32'h0);
    check("wr_c2_en", 32'(mem_en), 32'h0);
    check("wr_c2_rdata0", rdata0, 32'hDEADBEEF);
    next_cycle(); req1 = 1'b0; be1 = 4'b0000; smp();
    check("wr_c3_grant", 32'(grant), 32'h0);

    // tie round-robin from reset
    do_reset();
    next_cycle(); reset = 1'b1; req0 = 1'b1; req1 = 1'b1; addr0 = 11'h001; addr1 = 11'h002;
    smp();
    for (int c = 1; c <= 8; c++) begin
      int w;
      next_cycle();
      if (c == 8) begin req0 = 1'b0; req1 = 1'b0; end
      smp();
      w = ((c - 1) / 2) % 2;
      check($sformatf("rr_c%0d_grant", c), 32'(grant), (w == 1) ? 32'h2 : 32'h1);
      check($sformatf("rr_c%0d_ack0", c), 32'(ack0), 32'((c % 2 == 0) && (w == 0)));
      check($sformatf("rr_c%0d_ack1", c), 32'(ack1), 32'((c % 2 == 0) && (w == 1)));
      if (c % 2 == 1) check($sformatf("rr_c%0d_addr", c), 32'(mem_addr), (w == 1) ? 32'h2 : 32'h1);
    end
    next_cycle(); smp();
    check("rr_end_grant", 32'(grant), 32'h0);

    // lock limit: requester 1 locked, requester 0 joins after the first grant
    do_reset();
    next_cycle(); reset = 1'b1; req1 = 1'b1; lock1 = 1'b1; smp();
    for (int c = 1; c <= 24; c++) begin
      logic w1;
      next_cycle();
      if (c == 1) req0 = 1'b1;
      if (c == 24) begin req0 = 1'b0; req1 = 1'b0; lock1 = 1'b0; end
      smp();
      w1 = (c <= 10) || (c >= 13 && c <= 22);
      check($sformatf("lk_c%0d_grant", c), 32'(grant), w1 ? 32'h2 : 32'h1);
      check($sformatf("lk_c%0d_ack1", c), 32'(ack1), 32'((c % 2 == 0) && w1));
      check($sformatf("lk_c%0d_ack0", c), 32'(ack0), 32'((c % 2 == 0) && !w1));
    end
    next_cycle(); smp();
    check("lk_end_grant", 32'(grant), 32'h0);

    // reset during ACCESS abandons the access
    next_cycle(); req0 = 1'b1; addr0 = 11'h007; mem_rdata = 32'h55AA55AA; smp();
    next_cycle(); reset = 1'b0; smp();
    check("mr_c1_en", 32'(mem_en), 32'h1);
    check("mr_c1_grant", 32'(grant), 32'h1);
    next_cycle(); reset = 1'b1; smp();
    check("mr_c2_ack0", 32'(ack0), 32'h0);
    check("mr_c2_grant", 32'(grant), 32'h0);
    check("mr_c2_en", 32'(mem_en), 32'h0);
    check("mr_c2_busy", 32'(busy), 32'h0);
    check("mr_c2_rdata0", rdata0, 32'h0);
    next_cycle(); smp();
    check("mr_c3_en", 32'(mem_en), 32'h1);
    check("mr_c3_ack0", 32'(ack0), 32'h0);
    next_cycle(); smp();
    check("mr_c4_ack0", 32'(ack0), 32'h1);
    check("mr_c4_rdata0", rdata0, 32'h55AA55AA);
    next_cycle(); req0 = 1'b0; smp();

    // held req0 without lock: one access every 3 cycles
    next_cycle(); req0 = 1'b1; addr0 = 11'h3FF; smp();
    for (int c = 1; c <= 8; c++) begin
      next_cycle();
      mem_rdata = 32'hA0000000 + 32'(c);
      if (c == 8) req0 = 1'b0;
      smp();
      check($sformatf("hd_c%0d_ack0", c), 32'(ack0), 32'(c % 3 == 2));
      check($sformatf("hd_c%0d_en", c), 32'(mem_en), 32'(c % 3 == 1));
      check($sformatf("hd_c%0d_busy", c), 32'(busy), 32'(c % 3 != 0));
      if (c % 3 == 2) check($sformatf("hd_c%0d_rdata0", c), rdata0, 32'hA0000000 + 32'(c - 1));
    end

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
